ring_ingress: RTL and testbench
===============================

# ring_ingress

Host-side packetizer that sits directly upstream of ring FIFO 0 in the mini AIE 2x2 array. It replaces the raw "write every enabled cycle" feed. It accepts a byte stream from the pads under a valid/ready handshake and frames it as header, payload and optional checksum trailer. It pushes the result into the first ring FIFO one byte per cycle and honours that FIFO's full flag.

## Interface
Parameters:
- TRAILER_EN, default 1: when 1, append a checksum trailer byte to every packet; when 0, the packet ends after the last payload byte.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset (top-level `!rst_n & ena`).
- host_data  input  8  byte from the pads (ui_in).
- host_valid  input  1  host_data holds a byte to transfer.
- host_ready  output  1  block accepts host_data this cycle.
- fifo_data  output  8  byte presented to ring FIFO 0 data_in.
- fifo_wr_en  output  1  write strobe to ring FIFO 0 w_en.
- fifo_full  input  1  ring FIFO 0 full flag.
- cur_dest  output  2  destination rank latched from the current or last header.
- busy  output  1  a packet is in progress or a byte is held.
- pkt_count  output  8  count of completed packets, wraps.

## Operation
- Header byte format: [7:6] = dest rank 0..3; [5:0] = payload length L, 0..63.
- FSM states:
  - HDR (the idle state) accepts a header.
  - PAY accepts L payload bytes.
  - TRL emits the trailer and accepts nothing from the host.
- HDR transitions:
  - Header accepted with L>0 -> PAY.
  - Header accepted with L=0 -> TRL if TRAILER_EN, else stay in HDR; the packet is complete.
- PAY transitions: after the L-th payload byte is accepted -> TRL if TRAILER_EN, else HDR.
- TRL transition: -> HDR once the trailer is loaded into the output slot.
- Header accept actions:
  - Latch dest into cur_dest.
  - Load the remaining-byte counter with L.
  - Initialise the checksum to the header byte.
- Each payload accept: checksum += byte (mod 256); counter decrements.
- Trailer byte = checksum mod 256, i.e. header plus all payload bytes, truncated to 8 bits.
- Output slot: one 8-bit register plus an occupied flag.
  - fifo_wr_en = occupied & !fifo_full.
  - fifo_data = slot register.
  - The slot can load when empty or being drained this cycle.
- host_ready = (state is HDR or PAY) & slot can load.
- An accept is host_valid & host_ready. The accepted byte enters the slot unchanged. Bytes are never dropped or duplicated.
- busy = (state != HDR) | occupied.
- pkt_count increments by 1 on the FIFO write of the final packet byte (trailer, or last payload/header when TRAILER_EN=0). It wraps from 255 to 0.

## Timing
- Reset values:
  - state = HDR; slot empty.
  - fifo_wr_en = 0; fifo_data = 0x00.
  - host_ready = 0 while reset is asserted, and 1 the first cycle after reset releases.
  - cur_dest = 0; pkt_count = 0; busy = 0; checksum = 0; counter = 0.
- Latency: a byte accepted at edge N is written to the FIFO in the cycle after N if fifo_full=0.
- Throughput: 1 byte per cycle sustained with no full.
- Packet cost: L+1 host accepts plus 1 trailer cycle in which host_ready=0.
- fifo_full=1: the slot holds its value and fifo_wr_en=0. host_ready drops combinationally if the slot is occupied.
- Simultaneous drain and load in one cycle is legal; the slot stays occupied with the new byte.
- Entering TRL: the trailer loads on the first cycle the slot can load. The state returns to HDR on that same edge, so a new header can be accepted on the next cycle.
- Reset mid-packet aborts the packet:
  - The partial packet is abandoned and the held byte is discarded.
  - No trailer is emitted.
  - pkt_count returns to 0.
- host_valid=0 mid-payload stalls indefinitely with no timeout. State, counter and checksum are held.

## Test plan
- TRAILER_EN=1, send 0x83,0x10,0x20,0x30 back-to-back with fifo_full=0 -> FIFO writes 0x83,0x10,0x20,0x30,0xE3 on consecutive cycles; cur_dest=2; pkt_count=1; host_ready=0 for exactly one cycle (TRL).
- Header 0x40 (L=0) -> writes 0x40 then trailer 0x40; cur_dest=1. With TRAILER_EN=0 only 0x40 is written and pkt_count still increments.
- Checksum wrap: 0x02,0xFF,0xFF -> trailer 0x00.
- Backpressure: 0xC4 then 4 payload bytes, fifo_full held high 3 cycles during payload -> fifo_wr_en=0 and fifo_data stable during stall; host_ready=0 while the slot is occupied; all 6 bytes arrive in order with none lost.
- Reset asserted after 2 of 5 payload bytes -> next cycle fifo_wr_en=0, busy=0, pkt_count=0; a following packet 0x01,0xAA frames correctly with trailer 0xAB.
- TRAILER_EN=0, 256 back-to-back packets of header 0x00 -> pkt_count reads 0 after the 256th write, having passed 255.

Source files
------------

// File: rtl/ring_ingress_if.sv
// rtl/ring_ingress_if.sv - host byte handshake and ring FIFO 0 write port bundle
interface ring_ingress_if;
    logic [7:0] host_data;
    logic       host_valid;
    logic       host_ready;
    logic [7:0] fifo_data;
    logic       fifo_wr_en;
    logic       fifo_full;

    modport slave (
        input  host_data,
        input  host_valid,
        input  fifo_full,
        output host_ready,
        output fifo_data,
        output fifo_wr_en
    );

    modport master (
        output host_data,
        output host_valid,
        output fifo_full,
        input  host_ready,
        input  fifo_data,
        input  fifo_wr_en
    );
endinterface

// File: rtl/ring_ingress.sv
// rtl/ring_ingress.sv - frames host bytes as header/payload/checksum into ring FIFO 0
module ring_ingress #(
    parameter bit TRAILER_EN = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    ring_ingress_if.slave       bus,
    output logic [1:0]          cur_dest,
    output logic                busy,
    output logic [7:0]          pkt_count
);
    typedef enum logic [1:0] {HDR, PAY, TRL} state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] slot;
    logic       occupied;
    logic       slot_last;
    logic [5:0] remaining;
    logic [7:0] checksum;

    logic       drain;
    logic       can_load;
    logic       accept;
    logic       final_accept;
    logic       load_trailer;

    // Slot drains whenever it holds a byte and the FIFO has room; it may refill on the same edge.
    assign drain        = occupied & ~bus.fifo_full;
    assign can_load     = ~occupied | drain;
    assign accept       = bus.host_valid & bus.host_ready;
    assign load_trailer = (state == TRL) & can_load;
    // Last host byte of a packet: a zero-length header, or the final payload byte.
    assign final_accept = accept & (((state == HDR) & (bus.host_data[5:0] == 6'd0)) |
                                    ((state == PAY) & (remaining == 6'd1)));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HDR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: header opens a packet, the L-th payload byte closes it, trailer returns to idle.
    always_comb begin
        state_next = state;
        case (state)
            HDR: begin
                if (accept) begin
                    if (bus.host_data[5:0] != 6'd0) begin
                        state_next = PAY;
                    end else begin
                        state_next = TRAILER_EN ? TRL : HDR;
                    end
                end
            end
            PAY: begin
                if (final_accept) begin
                    state_next = TRAILER_EN ? TRL : HDR;
                end
            end
            TRL: begin
                if (can_load) begin
                    state_next = HDR;
                end
            end
            default: state_next = HDR;
        endcase
    end

    // Outputs: handshake and FIFO strobe follow the slot; host is never offered a slot in TRL.
    always_comb begin
        bus.host_ready = ~reset & (state != TRL) & can_load;
        bus.fifo_wr_en = drain;
        bus.fifo_data  = slot;
        busy           = (state != HDR) | occupied;
    end

    // Datapath: output slot, packet bookkeeping and completed-packet counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot      <= 8'h00;
            occupied  <= 1'b0;
            slot_last <= 1'b0;
            remaining <= 6'd0;
            checksum  <= 8'h00;
            cur_dest  <= 2'd0;
            pkt_count <= 8'd0;
        end else begin
            if (drain & slot_last) begin
                pkt_count <= pkt_count + 8'd1;
            end

            if (load_trailer) begin
                slot      <= checksum;
                occupied  <= 1'b1;
                slot_last <= 1'b1;
            end else if (accept) begin
                slot      <= bus.host_data;
                occupied  <= 1'b1;
                slot_last <= ~TRAILER_EN & final_accept;
            end else if (drain) begin
                occupied  <= 1'b0;
            end

            if (accept && state == HDR) begin
                cur_dest  <= bus.host_data[7:6];
                remaining <= bus.host_data[5:0];
                checksum  <= bus.host_data;
            end else if (accept && state == PAY) begin
                remaining <= remaining - 6'd1;
                checksum  <= checksum + bus.host_data;
            end
        end
    end
endmodule

// File: tb/tb_ring_ingress.sv
// tb/tb_ring_ingress.sv - randomized and directed bench for ring_ingress (trailer on and off)
module tb_ring_ingress;
    typedef logic [7:0] bq_t[$];

    logic       clk;
    logic       rst;
    logic [7:0] hd  [2];
    logic       hv  [2];
    logic       ff  [2];
    logic       rdy [2];
    logic       wr  [2];
    logic [7:0] fd  [2];
    logic [1:0] dest[2];
    logic       bsy [2];
    logic [7:0] pkt [2];

    int checks;
    int errors;
    int cycle;
    bq_t wlog[2];
    int  wtime[2][$];
    bit  saw255;

    ring_ingress_if bus0();
    ring_ingress_if bus1();

    assign bus0.host_data  = hd[0];
    assign bus0.host_valid = hv[0];
    assign bus0.fifo_full  = ff[0];
    assign rdy[0]          = bus0.host_ready;
    assign wr[0]           = bus0.fifo_wr_en;
    assign fd[0]           = bus0.fifo_data;
    assign bus1.host_data  = hd[1];
    assign bus1.host_valid = hv[1];
    assign bus1.fifo_full  = ff[1];
    assign rdy[1]          = bus1.host_ready;
    assign wr[1]           = bus1.fifo_wr_en;
    assign fd[1]           = bus1.fifo_data;

    ring_ingress #(.TRAILER_EN(1'b0)) dut0 (
        .clk(clk), .reset(rst), .bus(bus0.slave),
        .cur_dest(dest[0]), .busy(bsy[0]), .pkt_count(pkt[0])
    );
    ring_ingress #(.TRAILER_EN(1'b1)) dut1 (
        .clk(clk), .reset(rst), .bus(bus1.slave),
        .cur_dest(dest[1]), .busy(bsy[1]), .pkt_count(pkt[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Reference model: packet framing rules applied to a one-byte output slot.
    bit         m_valid[2];
    int         m_phase[2];   // 0 awaiting header, 1 payload, 2 trailer owed
    bit         m_occ  [2];
    bit         m_last [2];
    logic [7:0] m_slot [2];
    int         m_rem  [2];
    int         m_sum  [2];
    int         m_dest [2];
    int         m_cnt  [2];

    always @(negedge clk) begin
        bit e_wr, cl, e_rdy, acc, fin, ten;
        cycle++;
        for (int s = 0; s < 2; s++) begin
            ten   = (s == 1);
            e_wr  = m_occ[s] && !ff[s];
            cl    = !m_occ[s] || e_wr;
            e_rdy = (m_phase[s] != 2) && cl;
            if (wr[s]) begin
                wlog[s].push_back(fd[s]);
                wtime[s].push_back(cycle);
            end
            if (s == 0 && pkt[0] == 8'd255) saw255 = 1'b1;
            if (m_valid[s]) begin
                chk($sformatf("d%0d host_ready", s), int'(rdy[s]), int'(e_rdy && !rst));
                chk($sformatf("d%0d fifo_wr_en", s), int'(wr[s]), int'(e_wr));
                chk($sformatf("d%0d fifo_data", s), int'(fd[s]), int'(m_slot[s]));
                chk($sformatf("d%0d busy", s), int'(bsy[s]), int'(m_phase[s] != 0 || m_occ[s]));
                chk($sformatf("d%0d cur_dest", s), int'(dest[s]), m_dest[s]);
                chk($sformatf("d%0d pkt_count", s), int'(pkt[s]), m_cnt[s]);
            end
            if (rst) begin
                m_valid[s] = 1'b1;
                m_phase[s] = 0; m_occ[s] = 1'b0; m_last[s] = 1'b0; m_slot[s] = 8'h00;
                m_rem[s] = 0; m_sum[s] = 0; m_dest[s] = 0; m_cnt[s] = 0;
            end else if (m_valid[s]) begin
                acc = hv[s] && e_rdy;
                if (e_wr && m_last[s]) m_cnt[s] = (m_cnt[s] + 1) % 256;
                if (m_phase[s] == 2 && cl) begin
                    m_slot[s] = m_sum[s][7:0];
                    m_occ[s] = 1'b1; m_last[s] = 1'b1; m_phase[s] = 0;
                end else if (acc) begin
                    m_slot[s] = hd[s];
                    m_occ[s]  = 1'b1;
                    if (m_phase[s] == 0) begin
                        m_dest[s] = hd[s] / 64;
                        m_rem[s]  = hd[s] % 64;
                        m_sum[s]  = hd[s];
                        m_phase[s] = 1;
                    end else begin
                        m_sum[s] = (m_sum[s] + hd[s]) % 256;
                        m_rem[s] = m_rem[s] - 1;
                    end
                    fin = (m_rem[s] == 0);
                    m_last[s] = fin && !ten;
                    if (fin) m_phase[s] = ten ? 2 : 0;
                end else if (e_wr) begin
                    m_occ[s] = 1'b0;
                end
            end
        end
    end

    task automatic send(input int s, input bq_t bytes, input int gap_max);
        bit got;
        foreach (bytes[i]) begin
            if (gap_max > 0) begin
                hv[s] = 1'b0;
                repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            end
            hd[s] = bytes[i];
            hv[s] = 1'b1;
            got = 1'b0;
            for (int c = 0; c < 200 && !got; c++) begin
                @(negedge clk);
                got = rdy[s];
                @(posedge clk); #1;
            end
            if (!got) chk($sformatf("d%0d accept timeout", s), 0, 1);
        end
        hv[s] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_logs();
        wlog[0].delete(); wlog[1].delete();
        wtime[0].delete(); wtime[1].delete();
    endtask

    task automatic chk_log(input int s, input bq_t exp, input string nm);
        chk({nm, " count"}, wlog[s].size(), exp.size());
        foreach (exp[i]) begin
            if (i < wlog[s].size()) chk($sformatf("%s byte%0d", nm, i), int'(wlog[s][i]), int'(exp[i]));
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; hv[0] = 1'b0; hv[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic rand_stream(input int s, input int npkt);
        bq_t q;
        int len;
        for (int p = 0; p < npkt; p++) begin
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 5);
            q.delete();
            q.push_back({2'($urandom_range(0, 3)), 6'(len)});
            for (int b = 0; b < len; b++) q.push_back(8'($urandom));
            send(s, q, 2);
        end
    endtask

    initial begin
        bq_t q, e;
        bit rdone;
        checks = 0; errors = 0; cycle = 0; saw255 = 1'b0;
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            hd[s] = 8'h00; hv[s] = 1'b0; ff[s] = 1'b0; m_valid[s] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset host_ready", int'(rdy[1]), 0);
        chk("reset fifo_wr_en", int'(wr[1]), 0);
        chk("reset fifo_data", int'(fd[1]), 0);
        chk("reset busy", int'(bsy[1]), 0);
        chk("reset pkt_count", int'(pkt[1]), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("host_ready after reset", int'(rdy[1]), 1);
        @(posedge clk); #1;

        // Basic framing with trailer.
        clear_logs();
        q = {8'h83, 8'h10, 8'h20, 8'h30};
        send(1, q, 0);
        idle(4);
        e = {8'h83, 8'h10, 8'h20, 8'h30, 8'hE3};
        chk_log(1, e, "basic");
        if (wtime[1].size() == 5) chk("basic consecutive", wtime[1][4] - wtime[1][0], 4);
        chk("basic cur_dest", int'(dest[1]), 2);
        chk("basic pkt_count", int'(pkt[1]), 1);

        // Zero-length packet, trailer on and off.
        clear_logs();
        q = {8'h40};
        send(1, q, 0);
        send(0, q, 0);
        idle(4);
        e = {8'h40, 8'h40};
        chk_log(1, e, "zero len ten1");
        chk("zero len cur_dest", int'(dest[1]), 1);
        e = {8'h40};
        chk_log(0, e, "zero len ten0");
        chk("zero len ten0 pkt_count", int'(pkt[0]), 1);

        // Checksum wraps modulo 256.
        clear_logs();
        q = {8'h02, 8'hFF, 8'hFF};
        send(1, q, 0);
        idle(4);
        e = {8'h02, 8'hFF, 8'hFF, 8'h00};
        chk_log(1, e, "wrap");

        // Backpressure during payload.
        clear_logs();
        q = {8'hC4, 8'h01, 8'h02, 8'h03, 8'h04};
        fork
            send(1, q, 0);
            begin
                idle(2);
                ff[1] = 1'b1;
                @(negedge clk);
                chk("stall wr_en", int'(wr[1]), 0);
                chk("stall data", int'(fd[1]), 8'h01);
                chk("stall ready", int'(rdy[1]), 0);
                idle(2);
                @(negedge clk);
                chk("stall data held", int'(fd[1]), 8'h01);
                idle(1);
                ff[1] = 1'b0;
            end
        join
        idle(4);
        e = {8'hC4, 8'h01, 8'h02, 8'h03, 8'h04, 8'hCE};
        chk_log(1, e, "backpressure");

        // Reset mid-packet.
        q = {8'h05, 8'h11, 8'h22};
        send(1, q, 0);
        do_reset();
        @(negedge clk);
        chk("abort wr_en", int'(wr[1]), 0);
        chk("abort busy", int'(bsy[1]), 0);
        chk("abort pkt_count", int'(pkt[1]), 0);
        @(posedge clk); #1;
        clear_logs();
        q = {8'h01, 8'hAA};
        send(1, q, 0);
        idle(4);
        e = {8'h01, 8'hAA, 8'hAB};
        chk_log(1, e, "after abort");

        // 256 header-only packets without trailer wrap the counter.
        q = {8'h00};
        for (int i = 0; i < 256; i++) send(0, q, 0);
        idle(3);
        chk("wrap pkt_count", int'(pkt[0]), 0);
        chk("wrap passed 255", int'(saw255), 1);

        // Randomized traffic with random backpressure on both variants.
        rdone = 1'b0;
        fork
            begin
                fork
                    rand_stream(0, 40);
                    rand_stream(1, 40);
                join
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    ff[0] = ($urandom_range(0, 3) == 0);
                    ff[1] = ($urandom_range(0, 3) == 0);
                    @(posedge clk); #1;
                end
                ff[0] = 1'b0; ff[1] = 1'b0;
            end
        join
        idle(6);
        chk("random drained d0", int'(bsy[0]), 0);
        chk("random drained d1", int'(bsy[1]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
